// File: rtl/seven_segment_digit_scanner.sv
// seven_segment_digit_scanner
//   Time-multiplexes NUM_DIGITS packed nibbles onto one shared, registered
//   hex-to-7-segment decoder. Each digit owns a slot of REFRESH_DIV cycles.
//   The first DEAD_CYCLES cycles of a slot are dark to suppress ghosting.
//   New values are adopted only at frame boundaries.
//
//   Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading-zero
//   digits. When it is undefined, o_blank is tied to 0 and the port list is
//   unchanged.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous reset, active-high
//   i_value       packed nibbles, [3:0] = digit 0 (rightmost)
//   i_load        single-cycle strobe capturing i_value
//   o_binary_num  nibble for the current slot (feeds decoder i_binary_num)
//   o_digit_sel   one-hot digit enable, one cycle behind o_binary_num
//   o_blank       current slot is blanked (same alignment as o_digit_sel)
//   o_frame_done  one-cycle pulse after the last digit slot ends

module seven_segment_digit_scanner #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned DEAD_CYCLES = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_load,
    output logic [3:0]              o_binary_num,
    output logic [NUM_DIGITS-1:0]   o_digit_sel,
    output logic                    o_blank,
    output logic                    o_frame_done
);

    localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CntW-1:0]       CntLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0]       CntDead  = CntW'(DEAD_CYCLES);
    localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DigitOne = NUM_DIGITS'(1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("NUM_DIGITS must be in 2..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (DEAD_CYCLES >= REFRESH_DIV) begin : g_bad_dead_cycles
        $error("DEAD_CYCLES must be less than REFRESH_DIV");
    end

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_v_q, pend_v_d;
    logic [3:0]              binary_num_q, binary_num_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    blank_q, blank_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    slot_blank;

    // Per-digit blank flags, derived from the frame currently on display.
    always_comb begin
        blank_vec = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            // Walk from the most significant digit down; a digit is blank while
            // it and everything above it is zero. Digit 0 is always shown.
            for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
                zero_above = zero_above & (shadow_q[4*k +: 4] == 4'h0);
                if (k != 0) begin
                    blank_vec[k] = zero_above;
                end
            end
        end
`endif
    end

    assign slot_blank = blank_vec[idx_q];

    always_comb begin
        slot_end   = (cnt_q == CntLast);
        frame_wrap = slot_end && (idx_q == IdxLast);

        cnt_d = slot_end ? '0 : cnt_q + CntW'(1);

        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end

        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;

        if (frame_wrap) begin
            // A load on the wrap cycle goes straight to the display so digit 0
            // of the next frame already shows it.
            if (i_load) begin
                shadow_d = i_value;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                shadow_d = pending_q;
                pend_v_d = 1'b0;
            end
        end else if (i_load) begin
            pending_d = i_value;
            pend_v_d  = 1'b1;
        end

        // Nibble tracks the new index and new shadow on the same edge.
        binary_num_d = shadow_d[{idx_d, 2'b00} +: 4];

        // Enables lag the nibble by one cycle to match the decoder latency.
        digit_sel_d = ((cnt_q >= CntDead) && !slot_blank) ? (DigitOne << idx_q) : '0;
        blank_d     = slot_blank;

        frame_done_d = frame_wrap;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            binary_num_q <= '0;
            digit_sel_q  <= '0;
            blank_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            binary_num_q <= binary_num_d;
            digit_sel_q  <= digit_sel_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_binary_num = binary_num_q;
    assign o_digit_sel  = digit_sel_q;
    assign o_blank      = blank_q;
    assign o_frame_done = frame_done_q;

endmodule
